// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard controller for the 5-stage RISC-V pipeline. It keeps shadow copies of
// the instructions that are in flight in EX, MEM and WB. From these copies it
// derives the forwarding selects for the two EX operands. It also detects
// load-use hazards and turns a taken branch into stage flushes. Two saturating
// counters record stall cycles and flush events for performance debug.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ID_VALID            decode stage holds a valid instruction
//   ID_RS1/ID_RS2/ID_RD decode-stage source and destination registers
//   ID_WE               decode-stage instruction writes the register file
//   ID_MEM_REG          decode-stage instruction is a load
//   PC_R                registered branch-taken flag (branch now in MEM)
//   HU_RS1/HU_RS2       EX operand select: 0 = D1, 1 = BP_MEM, 2 = BP_WB
//   STALL_F/STALL_D     hold PC / hold IF/ID
//   FLUSH_D/E/M         bubble into IF/ID, ID/EX, EX/MEM
//   STALL_CNT           saturating count of load-use stall cycles
//   FLUSH_CNT           saturating count of branch flush cycles
// -----------------------------------------------------------------------------
module hazard_unit #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_VALID,
   input  logic [REG_W-1:0] ID_RS1,
   input  logic [REG_W-1:0] ID_RS2,
   input  logic [REG_W-1:0] ID_RD,
   input  logic             ID_WE,
   input  logic             ID_MEM_REG,
   input  logic             PC_R,
   output logic [1:0]       HU_RS1,
   output logic [1:0]       HU_RS2,
   output logic             STALL_F,
   output logic             STALL_D,
   output logic             FLUSH_D,
   output logic             FLUSH_E,
   output logic             FLUSH_M,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   localparam logic [1:0] SEL_D1  = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_WB  = 2'd2;

   // EX shadow slot
   logic             ex_valid_q, ex_valid_d;
   logic [REG_W-1:0] ex_rs1_q,   ex_rs1_d;
   logic [REG_W-1:0] ex_rs2_q,   ex_rs2_d;
   logic [REG_W-1:0] ex_rd_q,    ex_rd_d;
   logic             ex_we_q,    ex_we_d;
   logic             ex_load_q,  ex_load_d;
   // MEM shadow slot
   logic             mem_valid_q, mem_valid_d;
   logic [REG_W-1:0] mem_rd_q,    mem_rd_d;
   logic             mem_we_q,    mem_we_d;
   // WB shadow slot
   logic             wb_valid_q, wb_valid_d;
   logic [REG_W-1:0] wb_rd_q,    wb_rd_d;
   logic             wb_we_q,    wb_we_d;
   // event counters
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic mem_wr, wb_wr;
   logic load_use;
   logic stall, flush_e, flush_br;

   // A slot's write enable only counts when the slot is valid and targets a real register.
   assign mem_wr = mem_valid_q && mem_we_q && (mem_rd_q != '0);
   assign wb_wr  = wb_valid_q  && wb_we_q  && (wb_rd_q  != '0);

   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] rs,
      input logic             m_wr,
      input logic [REG_W-1:0] m_rd,
      input logic             w_wr,
      input logic [REG_W-1:0] w_rd
   );
      logic [1:0] sel;
      sel = SEL_D1;
      if (rs != '0) begin
         if (m_wr && (m_rd == rs)) begin
            sel = SEL_MEM;
         end else if (w_wr && (w_rd == rs)) begin
            sel = SEL_WB;
         end
      end
      return sel;
   endfunction

   assign load_use = ID_VALID && ex_valid_q && ex_load_q && (ex_rd_q != '0) &&
                     ((ex_rd_q == ID_RS1) || (ex_rd_q == ID_RS2));

   // A taken branch overrides the load-use stall because the stalled consumer is flushed anyway.
   always_comb begin
      stall    = 1'b0;
      flush_e  = 1'b0;
      flush_br = 1'b0;
      HU_RS1   = SEL_D1;
      HU_RS2   = SEL_D1;
      if (!rst) begin
         flush_br = PC_R;
         stall    = load_use && !PC_R;
         flush_e  = load_use || PC_R;
         HU_RS1   = fwd_sel(ex_rs1_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
         HU_RS2   = fwd_sel(ex_rs2_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
      end
   end

   assign STALL_F   = stall;
   assign STALL_D   = stall;
   assign FLUSH_D   = flush_br;
   assign FLUSH_E   = flush_e;
   assign FLUSH_M   = flush_br;
   assign STALL_CNT = stall_cnt_q;
   assign FLUSH_CNT = flush_cnt_q;

   always_comb begin
      // WB takes MEM unconditionally
      wb_valid_d = mem_valid_q;
      wb_rd_d    = mem_rd_q;
      wb_we_d    = mem_we_q;

      // MEM takes EX unless the branch squashes it
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_we_d    = ex_we_q;
      if (flush_br) begin
         mem_valid_d = 1'b0;
         mem_rd_d    = '0;
         mem_we_d    = 1'b0;
      end

      // EX takes decode unless a bubble is inserted
      ex_valid_d = ID_VALID;
      ex_rs1_d   = ID_RS1;
      ex_rs2_d   = ID_RS2;
      ex_rd_d    = ID_RD;
      ex_we_d    = ID_VALID && ID_WE;
      ex_load_d  = ID_VALID && ID_MEM_REG;
      if (flush_e) begin
         ex_valid_d = 1'b0;
         ex_rs1_d   = '0;
         ex_rs2_d   = '0;
         ex_rd_d    = '0;
         ex_we_d    = 1'b0;
         ex_load_d  = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (flush_br && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q  <= 1'b0;
         ex_rs1_q    <= '0;
         ex_rs2_q    <= '0;
         ex_rd_q     <= '0;
         ex_we_q     <= 1'b0;
         ex_load_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         mem_we_q    <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_we_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_rs1_q    <= ex_rs1_d;
         ex_rs2_q    <= ex_rs2_d;
         ex_rd_q     <= ex_rd_d;
         ex_we_q     <= ex_we_d;
         ex_load_q   <= ex_load_d;
         mem_valid_q <= mem_valid_d;
         mem_rd_q    <= mem_rd_d;
         mem_we_q    <= mem_we_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_we_q     <= wb_we_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Self-checking bench for hazard_unit with CNT_W = 4, so that counter
// saturation can be reached. The reference model holds the in-flight
// instructions as an age-ordered array (EX, MEM, WB). For each EX operand it
// looks for the nearest older producer.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = 15;

   logic             clk;
   logic             rst;
   logic             id_valid;
   logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
   logic             id_we, id_mem_reg, pc_r;
   logic [1:0]       hu_rs1, hu_rs2;
   logic             stall_f, stall_d, flush_d, flush_e, flush_m;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int unsigned n_checks;
   int unsigned n_fail;

   hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ID_VALID   (id_valid),
      .ID_RS1     (id_rs1),
      .ID_RS2     (id_rs2),
      .ID_RD      (id_rd),
      .ID_WE      (id_we),
      .ID_MEM_REG (id_mem_reg),
      .PC_R       (pc_r),
      .HU_RS1     (hu_rs1),
      .HU_RS2     (hu_rs2),
      .STALL_F    (stall_f),
      .STALL_D    (stall_d),
      .FLUSH_D    (flush_d),
      .FLUSH_E    (flush_e),
      .FLUSH_M    (flush_m),
      .STALL_CNT  (stall_cnt),
      .FLUSH_CNT  (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      bit       v;
      bit [4:0] rs1, rs2, rd;
      bit       we, ld;
   } ins_t;

   ins_t        pl[3];      // index = age: 0 EX, 1 MEM, 2 WB
   int unsigned m_stall, m_flush;

   function automatic ins_t bubble();
      ins_t b;
      b.v = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.we = 0; b.ld = 0;
      return b;
   endfunction

   // nearest older producer of rs wins; its age is the select code
   function automatic int unsigned m_fwd(bit [4:0] rs);
      if (rs == 0) return 0;
      for (int k = 1; k <= 2; k++)
         if (pl[k].v && pl[k].we && pl[k].rd != 0 && pl[k].rd == rs) return k;
      return 0;
   endfunction

   function automatic bit m_load_use();
      return id_valid && pl[0].v && pl[0].ld && pl[0].rd != 0 &&
             (pl[0].rd == id_rs1 || pl[0].rd == id_rs2);
   endfunction

   task automatic model_edge();
      bit   lu;
      ins_t d;
      if (rst) begin
         for (int k = 0; k < 3; k++) pl[k] = bubble();
         m_stall = 0;
         m_flush = 0;
      end else begin
         lu = m_load_use();
         if (lu && !pc_r && m_stall < CNT_MAX) m_stall++;
         if (pc_r && m_flush < CNT_MAX) m_flush++;
         d.v = id_valid; d.rs1 = id_rs1; d.rs2 = id_rs2; d.rd = id_rd;
         d.we = id_valid && id_we; d.ld = id_valid && id_mem_reg;
         pl[2] = pl[1];
         pl[1] = pc_r ? bubble() : pl[0];
         pl[0] = (lu || pc_r) ? bubble() : d;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      bit lu;
      lu = m_load_use();
      if (rst) begin
         check("hu_rs1_rst", 32'(hu_rs1), 0);
         check("hu_rs2_rst", 32'(hu_rs2), 0);
         check("stall_rst",  32'({stall_f, stall_d}), 0);
         check("flush_rst",  32'({flush_d, flush_e, flush_m}), 0);
      end else begin
         check("hu_rs1",  32'(hu_rs1), m_fwd(pl[0].rs1));
         check("hu_rs2",  32'(hu_rs2), m_fwd(pl[0].rs2));
         check("stall_f", 32'(stall_f), 32'(lu && !pc_r));
         check("stall_d", 32'(stall_d), 32'(lu && !pc_r));
         check("flush_d", 32'(flush_d), 32'(pc_r));
         check("flush_e", 32'(flush_e), 32'(lu || pc_r));
         check("flush_m", 32'(flush_m), 32'(pc_r));
      end
      check("stall_cnt", 32'(stall_cnt), m_stall);
      check("flush_cnt", 32'(flush_cnt), m_flush);
   endtask

   task automatic drive(input bit r, input bit v, input bit [4:0] a, input bit [4:0] b,
                        input bit [4:0] d, input bit we, input bit ld, input bit pc);
      rst = r; id_valid = v; id_rs1 = a; id_rs2 = b; id_rd = d;
      id_we = we; id_mem_reg = ld; pc_r = pc;
      #3;
      check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic ins(input bit v, input bit [4:0] a, input bit [4:0] b,
                      input bit [4:0] d, input bit we, input bit ld);
      drive(0, v, a, b, d, we, ld, 0);
      tick();
   endtask

   task automatic nops(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) ins(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < 3; k++) pl[k] = bubble();
      m_stall = 0;
      m_flush = 0;

      // reset for two cycles with active-looking inputs
      rst = 1; id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_rd = 5;
      id_we = 1; id_mem_reg = 1; pc_r = 1;
      #3;
      tick();
      drive(1, 1, 5, 5, 5, 1, 1, 1);
      check("rst_stall_cnt", 32'(stall_cnt), 0);
      check("rst_flush_cnt", 32'(flush_cnt), 0);
      tick();
      drive(0, 1, 5, 6, 7, 1, 0, 0);
      check("post_rst_hu1", 32'(hu_rs1), 0);
      check("post_rst_hu2", 32'(hu_rs2), 0);
      tick();
      nops(3);

      // MEM bypass
      ins(1, 1, 2, 5, 1, 0);
      ins(1, 5, 5, 6, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("mem_fwd_rs1", 32'(hu_rs1), 1);
      check("mem_fwd_rs2", 32'(hu_rs2), 1);
      tick();
      nops(3);

      // WB bypass
      ins(1, 1, 2, 5, 1, 0);
      ins(0, 0, 0, 0, 0, 0);
      ins(1, 5, 1, 6, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("wb_fwd_rs1", 32'(hu_rs1), 2);
      check("wb_fwd_rs2", 32'(hu_rs2), 0);
      tick();
      nops(3);

      // MEM priority over WB
      ins(1, 1, 2, 5, 1, 0);
      ins(1, 1, 2, 5, 1, 0);
      ins(1, 5, 5, 7, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("prio_rs1", 32'(hu_rs1), 1);
      check("prio_rs2", 32'(hu_rs2), 1);
      tick();
      nops(3);

      // x0 is never forwarded
      ins(1, 1, 2, 0, 1, 0);
      ins(1, 0, 0, 6, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("x0_rs1", 32'(hu_rs1), 0);
      check("x0_rs2", 32'(hu_rs2), 0);
      tick();
      nops(3);

      // load-use: one stall cycle, then WB bypass
      ins(1, 1, 2, 7, 1, 1);
      drive(0, 1, 7, 1, 8, 1, 0, 0);
      check("lu_stall_f", 32'(stall_f), 1);
      check("lu_stall_d", 32'(stall_d), 1);
      check("lu_flush_e", 32'(flush_e), 1);
      tick();
      drive(0, 1, 7, 1, 8, 1, 0, 0);
      check("lu_once", 32'(stall_f), 0);
      check("lu_cnt", 32'(stall_cnt), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("lu_wb_rs1", 32'(hu_rs1), 2);
      check("lu_wb_rs2", 32'(hu_rs2), 0);
      tick();
      nops(3);

      // load followed by an independent instruction: no stall
      ins(1, 1, 2, 7, 1, 1);
      drive(0, 1, 1, 2, 8, 1, 0, 0);
      check("no_lu_stall", 32'(stall_f), 0);
      tick();
      nops(3);

      // branch in the load-use cycle: flush wins
      ins(1, 1, 2, 7, 1, 1);
      drive(0, 1, 7, 1, 8, 1, 0, 1);
      check("br_flush_d", 32'(flush_d), 1);
      check("br_flush_e", 32'(flush_e), 1);
      check("br_flush_m", 32'(flush_m), 1);
      check("br_stall_f", 32'(stall_f), 0);
      check("br_stall_d", 32'(stall_d), 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("br_flush_cnt", 32'(flush_cnt), 1);
      check("br_stall_cnt", 32'(stall_cnt), 1);
      check("br_hu1", 32'(hu_rs1), 0);
      check("br_hu2", 32'(hu_rs2), 0);
      tick();
      nops(3);

      // stall counter saturation
      for (int i = 0; i < 20; i++) begin
         ins(1, 1, 2, 7, 1, 1);
         ins(1, 7, 0, 8, 1, 0);
         ins(1, 7, 0, 8, 1, 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("sat_cnt", 32'(stall_cnt), 15);
      tick();
      ins(1, 1, 2, 7, 1, 1);
      ins(1, 7, 0, 8, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("sat_hold", 32'(stall_cnt), 15);
      tick();

      // randomized traffic against the model, including occasional resets
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 9) < 1));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
